// File: rtl/common_pkg.sv
// Shared scalar types used across the pipeline blocks.
package common;
  typedef logic [4:0]  creg_addr_t;
  typedef logic [63:0] u64;
endpackage

// File: rtl/pipes_pkg.sv
// Pipeline-control types: sequencer state and the bundled stall/flush/redirect controls.
package pipes;
  import common::*;

  typedef enum logic [1:0] {RUN, MULDIV, REDIR_PEND} ctrl_state_t;

  typedef struct packed {
    logic stall_f;
    logic stall_fd;
    logic stall_de;
    logic stall_em;
    logic flush_fd;
    logic flush_de;
    logic redirect_valid;
    u64   redirect_pc;
  } pipe_ctrl_t;
endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use compare between the load in EX and the sources of the instruction in decode.
module hazard_detect (
  input  logic       e_is_load,
  input  logic [4:0] e_rd,
  input  logic [4:0] d_rs1,
  input  logic [4:0] d_rs2,
  output logic       load_use
);
  // x0 is hardwired zero, so a load targeting it never produces a dependence
  assign load_use = e_is_load && (e_rd != 5'd0) && ((e_rd == d_rs1) || (e_rd == d_rs2));
endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush/redirect sequencer for the 5-stage pipeline: dmem > mul/div > branch > load-use > imem.
module pipe_ctrl
  import common::*;
  import pipes::*;
#(
  parameter int          MULDIV_CYCLES = 64,
  parameter logic [63:0] PC_RESET      = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_busy,
  input  logic        dmem_busy,
  input  logic [4:0]  d_rs1,
  input  logic [4:0]  d_rs2,
  input  logic        e_is_load,
  input  logic [4:0]  e_rd,
  input  logic        e_muldiv,
  input  logic        e_br_taken,
  input  logic [63:0] e_br_target,
  output logic        stall_f,
  output logic        stall_fd,
  output logic        stall_de,
  output logic        stall_em,
  output logic        flush_fd,
  output logic        flush_de,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        muldiv_done
);
  localparam int              CNT_W    = $clog2(MULDIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULDIV_CYCLES - 1);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  u64               pend_pc_q, pend_pc_d;
  pipe_ctrl_t       ctl;
  logic             done;
  logic             load_use;
  logic             md_busy;

  hazard_detect u_hazard (
    .e_is_load (e_is_load),
    .e_rd      (e_rd),
    .d_rs1     (d_rs1),
    .d_rs2     (d_rs2),
    .load_use  (load_use)
  );

  // The RUN cycle that first sees the op is count 0, so EX is held exactly MULDIV_CYCLES cycles
  assign md_busy = ((state_q == RUN) && e_muldiv) ||
                   ((state_q == MULDIV) && (cnt_q != CNT_LAST));

  always_comb begin
    ctl             = '0;
    ctl.redirect_pc = pend_pc_q;
    done            = 1'b0;
    state_d         = state_q;
    cnt_d           = cnt_q;
    pend_pc_d       = pend_pc_q;
    if (!reset) begin
      ctl.redirect_pc = PC_RESET;
    end else if (dmem_busy) begin
      ctl.stall_f  = 1'b1;
      ctl.stall_fd = 1'b1;
      ctl.stall_de = 1'b1;
      ctl.stall_em = 1'b1;
    end else if (md_busy) begin
      ctl.stall_f  = 1'b1;
      ctl.stall_fd = 1'b1;
      ctl.stall_de = 1'b1;
      if (state_q == RUN) begin
        state_d = MULDIV;
        cnt_d   = CNT_W'(1);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      if (state_q == MULDIV) begin
        done    = 1'b1;
        state_d = RUN;
        cnt_d   = '0;
      end
      if (state_q == REDIR_PEND) begin
        // Decode holds whatever the discarded fetch produced; keep squashing it
        ctl.flush_fd = 1'b1;
        if (e_br_taken) pend_pc_d = e_br_target;
        if (!imem_busy) begin
          ctl.redirect_valid = 1'b1;
          ctl.redirect_pc    = e_br_taken ? e_br_target : pend_pc_q;
          state_d            = RUN;
        end
      end else if (e_br_taken) begin
        ctl.flush_fd = 1'b1;
        ctl.flush_de = 1'b1;
        if (!imem_busy) begin
          ctl.redirect_valid = 1'b1;
          ctl.redirect_pc    = e_br_target;
        end else begin
          pend_pc_d = e_br_target;
          state_d   = REDIR_PEND;
        end
      end else if (load_use || imem_busy) begin
        ctl.stall_f  = 1'b1;
        ctl.stall_fd = 1'b1;
        ctl.flush_de = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign stall_f        = ctl.stall_f;
  assign stall_fd       = ctl.stall_fd;
  assign stall_de       = ctl.stall_de;
  assign stall_em       = ctl.stall_em;
  assign flush_fd       = ctl.flush_fd;
  assign flush_de       = ctl.flush_de;
  assign redirect_valid = ctl.redirect_valid;
  assign redirect_pc    = ctl.redirect_pc;
  assign muldiv_done    = done;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table for single-cycle hazards, hand sequences for multi-cycle cases.
module tb_pipe_ctrl;
  localparam logic [63:0] PC_RST = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_busy, dmem_busy, e_is_load, e_muldiv, e_br_taken;
  logic [4:0]  d_rs1, d_rs2, e_rd;
  logic [63:0] e_br_target;
  logic        stall_f, stall_fd, stall_de, stall_em, flush_fd, flush_de;
  logic        redirect_valid, muldiv_done;
  logic [63:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.MULDIV_CYCLES(4), .PC_RESET(PC_RST)) dut (
    .clk(clk), .reset(reset),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .d_rs1(d_rs1), .d_rs2(d_rs2),
    .e_is_load(e_is_load), .e_rd(e_rd), .e_muldiv(e_muldiv),
    .e_br_taken(e_br_taken), .e_br_target(e_br_target),
    .stall_f(stall_f), .stall_fd(stall_fd), .stall_de(stall_de), .stall_em(stall_em),
    .flush_fd(flush_fd), .flush_de(flush_de),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .muldiv_done(muldiv_done)
  );

  always #5 clk = ~clk;

  // flag order: {stall_f, stall_fd, stall_de, stall_em, flush_fd, flush_de, redirect_valid, muldiv_done}
  typedef struct {
    string       name;
    logic        imem, dmem, ld, md, br;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] tgt;
    logic [7:0]  exp;
    logic [63:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] flags();
    return {stall_f, stall_fd, stall_de, stall_em, flush_fd, flush_de, redirect_valid, muldiv_done};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic imem, input logic dmem, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic ld, input logic [4:0] rd, input logic md, input logic br,
                       input logic [63:0] tgt);
    imem_busy = imem; dmem_busy = dmem; d_rs1 = rs1; d_rs2 = rs2;
    e_is_load = ld; e_rd = rd; e_muldiv = md; e_br_taken = br; e_br_target = tgt;
  endtask

  task automatic idle();
    drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 64'h0);
  endtask

  task automatic add(input string nm, input logic imem, input logic dmem, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic ld, input logic [4:0] rd, input logic md,
                     input logic br, input logic [63:0] tgt, input logic [7:0] exp, input logic [63:0] pc);
    vec_t v;
    v.name = nm; v.imem = imem; v.dmem = dmem; v.rs1 = rs1; v.rs2 = rs2; v.ld = ld; v.rd = rd;
    v.md = md; v.br = br; v.tgt = tgt; v.exp = exp; v.exp_pc = pc;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b0;
    idle();

    // reset holds every control low regardless of inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
            5'($urandom), 1'($urandom), 1'($urandom), {$urandom, $urandom});
      #1;
      chk("rst_flags", 64'(flags()), 64'h0);
      chk("rst_pc", redirect_pc, PC_RST);
    end
    @(negedge clk);
    reset = 1'b1;
    idle();
    #1 chk("post_rst_idle", 64'(flags()), 64'h0);

    //   name          imem dmem rs1 rs2 ld rd md br tgt                 exp          pc
    add("lu_rs2",      0, 0, 5'd3, 5'd5, 1, 5'd5, 0, 0, 64'h0,            8'b1100_0100, 64'h0);
    add("lu_rs1",      0, 0, 5'd7, 5'd1, 1, 5'd7, 0, 0, 64'h0,            8'b1100_0100, 64'h0);
    add("lu_x0",       0, 0, 5'd0, 5'd0, 1, 5'd0, 0, 0, 64'h0,            8'b0000_0000, 64'h0);
    add("no_load",     0, 0, 5'd3, 5'd5, 0, 5'd5, 0, 0, 64'h0,            8'b0000_0000, 64'h0);
    add("imem_busy",   1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 64'h0,            8'b1100_0100, 64'h0);
    add("dmem_busy",   0, 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 64'h0,            8'b1111_0000, 64'h0);
    add("br_idle",     0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 64'h8000_0100,    8'b0000_1110, 64'h8000_0100);
    add("br_and_lu",   0, 0, 5'd5, 5'd2, 1, 5'd5, 0, 1, 64'h8000_0140,    8'b0000_1110, 64'h8000_0140);
    add("dmem_br",     0, 1, 5'd0, 5'd0, 0, 5'd0, 0, 1, 64'h8000_0180,    8'b1111_0000, 64'h0);
    add("dmem_md",     0, 1, 5'd0, 5'd0, 0, 5'd0, 1, 0, 64'h0,            8'b1111_0000, 64'h0);
    add("dmem_im_lu",  1, 1, 5'd9, 5'd0, 1, 5'd9, 0, 0, 64'h0,            8'b1111_0000, 64'h0);
    add("all_idle",    0, 0, 5'd4, 5'd6, 0, 5'd8, 0, 0, 64'h0,            8'b0000_0000, 64'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].imem, vecs[i].dmem, vecs[i].rs1, vecs[i].rs2, vecs[i].ld, vecs[i].rd,
            vecs[i].md, vecs[i].br, vecs[i].tgt);
      #1;
      chk(vecs[i].name, 64'(flags()), 64'(vecs[i].exp));
      if (vecs[i].exp[1]) chk({vecs[i].name, "_pc"}, redirect_pc, vecs[i].exp_pc);
    end

    // mul/div, 4 cycles: three stalled cycles, done on the fourth
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 64'h0);
      #1 chk($sformatf("md_c%0d", k), 64'(flags()), (k < 3) ? 64'hE0 : 64'h01);
    end
    @(negedge clk);
    idle();
    #1 chk("md_after", 64'(flags()), 64'h0);

    // mul/div with two dmem_busy cycles mid-op: done slips by exactly two cycles
    for (int k = 0; k < 6; k++) begin
      logic [7:0] e;
      @(negedge clk);
      drive(0, (k == 2 || k == 3), 5'd0, 5'd0, 0, 5'd0, 1, 0, 64'h0);
      if (k == 2 || k == 3) e = 8'b1111_0000;
      else if (k == 5)      e = 8'b0000_0001;
      else                  e = 8'b1110_0000;
      #1 chk($sformatf("md_dm_c%0d", k), 64'(flags()), 64'(e));
    end
    @(negedge clk);
    idle();
    #1 chk("md_dm_after", 64'(flags()), 64'h0);

    // branch while imem busy: held redirect, released when fetch goes idle
    @(negedge clk);
    drive(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 64'h8000_0200);
    #1 chk("brp_c0", 64'(flags()), 64'h0C);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      drive(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 64'h0);
      #1 chk($sformatf("brp_c%0d", k), 64'(flags()), 64'h08);
    end
    @(negedge clk);
    idle();
    #1;
    chk("brp_redir", 64'(flags()), 64'h0A);
    chk("brp_pc", redirect_pc, 64'h8000_0200);
    @(negedge clk);
    #1 chk("brp_after", 64'(flags()), 64'h0);

    // reset while a redirect is pending: it must be lost
    @(negedge clk);
    drive(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 64'h8000_0300);
    #1 chk("rp_c0", 64'(flags()), 64'h0C);
    @(negedge clk);
    drive(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 64'h0);
    #1 chk("rp_c1", 64'(flags()), 64'h08);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rp_rst_flags", 64'(flags()), 64'h0);
    chk("rp_rst_pc", redirect_pc, PC_RST);
    @(negedge clk);
    idle();
    #1;
    chk("rp_rst_imem_idle", 64'(flags()), 64'h0);
    chk("rp_rst_pc2", redirect_pc, PC_RST);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("rp_release", 64'(flags()), 64'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk($sformatf("rp_post%0d", k), 64'(flags()), 64'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
